// File: rtl/axi_fifo.sv
// AXI-stream FIFO, 2^SIZE words, first-word-fall-through, packet-end flag carried as data MSB.
// Latency: a word written into an empty FIFO is presented two edges later (RAM read + output register).
// Backpressure: i_tready drops only when all 2^SIZE entries are held; o_tvalid/o_tdata hold until read.
// Optional macro AXI_FIFO_OCCUPANCY_EN adds the occupied/space counters; otherwise both read as 0.
module axi_fifo #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [SIZE:0]    space,
  output logic [SIZE:0]    occupied
);

  localparam int            DEPTH   = 1 << SIZE;
  localparam logic [SIZE-1:0] PTR_ONE = SIZE'(1);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // wr_ptr: next RAM slot to write; fetch_ptr: next slot to read into the pipeline;
  // ret_ptr: slot of the word in the output register, freed only when it is read out,
  // so words in flight keep their RAM slot and the total held never exceeds 2^SIZE.
  logic [SIZE-1:0]  wr_ptr;
  logic [SIZE-1:0]  fetch_ptr;
  logic [SIZE-1:0]  ret_ptr;
  logic             full_r;
  logic [WIDTH-1:0] ram_q;
  logic             q_vld;
  logic             out_vld;
  logic [WIDTH-1:0] out_dat;

  logic flush;
  logic wr_en;
  logic rd_en;
  logic out_load;
  logic fetch_avail;
  logic fetch_en;

  assign flush    = reset | clear;
  assign i_tready = ~full_r;
  assign o_tvalid = out_vld;
  assign o_tdata  = out_dat;
  assign wr_en    = i_tvalid & ~full_r;
  assign rd_en    = out_vld & o_tready;
  assign out_load = ~out_vld | rd_en;

  // Equal pointers are ambiguous only when full: then words remain to fetch unless
  // the pipeline already holds them (only possible for very small depths).
  assign fetch_avail = (fetch_ptr != wr_ptr) | (full_r & ~q_vld & ~out_vld);
  assign fetch_en    = fetch_avail & (~q_vld | out_load);

  // Storage write port
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      mem[wr_ptr] <= i_tdata;
    end
  end

  // Registered RAM read feeding the output stage
  always_ff @(posedge clk) begin
    if (flush) begin
      ram_q <= '0;
    end else if (fetch_en) begin
      ram_q <= mem[fetch_ptr];
    end
  end

  // Pointers and full flag
  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr    <= '0;
      fetch_ptr <= '0;
      ret_ptr   <= '0;
      full_r    <= 1'b0;
    end else begin
      if (wr_en)    wr_ptr    <= wr_ptr + PTR_ONE;
      if (fetch_en) fetch_ptr <= fetch_ptr + PTR_ONE;
      if (rd_en)    ret_ptr   <= ret_ptr + PTR_ONE;
      if (wr_en && !rd_en && ((wr_ptr + PTR_ONE) == ret_ptr)) begin
        full_r <= 1'b1;
      end else if (rd_en && !wr_en) begin
        full_r <= 1'b0;
      end
    end
  end

  // Pipeline valid and output register; output only reloads when empty or being read
  always_ff @(posedge clk) begin
    if (flush) begin
      q_vld   <= 1'b0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      if (fetch_en) begin
        q_vld <= 1'b1;
      end else if (out_load) begin
        q_vld <= 1'b0;
      end
      if (out_load) begin
        out_vld <= q_vld;
        if (q_vld) out_dat <= ram_q;
      end
    end
  end

`ifdef AXI_FIFO_OCCUPANCY_EN
  localparam logic [SIZE:0] CNT_ONE  = (SIZE+1)'(1);
  localparam logic [SIZE:0] CNT_FULL = {1'b1, {SIZE{1'b0}}};

  logic [SIZE:0] occ_r;
  logic [SIZE:0] spc_r;

  // Occupancy counters; a simultaneous read and write leaves both unchanged
  always_ff @(posedge clk) begin
    if (flush) begin
      occ_r <= '0;
      spc_r <= CNT_FULL;
    end else if (wr_en && !rd_en) begin
      occ_r <= occ_r + CNT_ONE;
      spc_r <= spc_r - CNT_ONE;
    end else if (rd_en && !wr_en) begin
      occ_r <= occ_r - CNT_ONE;
      spc_r <= spc_r + CNT_ONE;
    end
  end

  assign occupied = occ_r;
  assign space    = spc_r;
`else
  assign occupied = '0;
  assign space    = '0;
`endif

endmodule

// File: tb/tb_axi_fifo.sv
// Directed bench for axi_fifo at WIDTH=17, SIZE=4 (16 entries).
// Inputs change #1 after each rising edge; outputs are sampled at that same point.
// A queue scoreboard checks every word read against the words accepted.
module tb_axi_fifo;
  localparam int W = 17;
  localparam int S = 4;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset, clear;
  logic [W-1:0] i_tdata;
  logic         i_tvalid, i_tready;
  logic [W-1:0] o_tdata;
  logic         o_tvalid, o_tready;
  logic [S:0]   space, occupied;

  int n_total = 0;
  int n_pass  = 0;
  int out_last = 0;
  logic [W-1:0] exp_q[$];

  axi_fifo #(.WIDTH(W), .SIZE(S)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .space(space), .occupied(occupied)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic check_occ(input int occ);
`ifdef AXI_FIFO_OCCUPANCY_EN
    check("occupied", 32'(occupied), 32'(occ));
    check("space", 32'(space), 32'(DEPTH - occ));
`else
    check("occupied_tied", 32'(occupied), 32'd0);
    check("space_tied", 32'(space), 32'd0);
`endif
  endtask

  // One clock: score this edge's read/write, then advance to #1 after the edge.
  task automatic cycle();
    logic         wr, rd;
    logic [W-1:0] e;
    wr = i_tvalid && i_tready;
    rd = o_tvalid && o_tready;
    if (rd) begin
      if (exp_q.size() == 0) begin
        check("unexpected_read", 32'(o_tdata), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("data", 32'(o_tdata), 32'(e));
      end
      if (o_tdata[W-1]) out_last++;
    end
    if (wr) exp_q.push_back(i_tdata);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    for (int k = 0; k < budget && (exp_q.size() != 0 || o_tvalid); k++) cycle();
    check("drain_left", 32'(exp_q.size()), 32'd0);
    o_tready = 1'b0;
  endtask

  initial begin
    int acc;
    int stalls;
    int exp_sum;

    reset = 1'b1; clear = 1'b0;
    i_tdata = 17'h1_5555; i_tvalid = 1'b1; o_tready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0; i_tvalid = 1'b0;

    // Reset state; writes offered during reset are ignored
    check("rst_o_tvalid", 32'(o_tvalid), 32'd0);
    check("rst_i_tready", 32'(i_tready), 32'd1);
    check("rst_o_tdata", 32'(o_tdata), 32'd0);
    check_occ(0);
    repeat (3) cycle();
    check("rst_no_ghost", 32'(o_tvalid), 32'd0);

    // Single write into empty FIFO: visible after edge N+2
    i_tdata = 17'h1_ABCD; i_tvalid = 1'b1;
    cycle();
    i_tvalid = 1'b0;
    check("lat_n0", 32'(o_tvalid), 32'd0);
    check_occ(1);
    cycle();
    check("lat_n1", 32'(o_tvalid), 32'd0);
    cycle();
    check("lat_n2_vld", 32'(o_tvalid), 32'd1);
    check("lat_n2_dat", 32'(o_tdata), 32'h1_ABCD);
    cycle();
    check("stable_vld", 32'(o_tvalid), 32'd1);
    check("stable_dat", 32'(o_tdata), 32'h1_ABCD);
    o_tready = 1'b1;
    cycle();
    o_tready = 1'b0;
    check("empty_after_read", 32'(o_tvalid), 32'd0);
    check_occ(0);

    // Full boundary: 20 offered, 16 accepted
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      i_tdata = 17'(32'h100 + i); i_tvalid = 1'b1;
      if (i_tready) acc++;
      cycle();
    end
    check("full_accepted", 32'(acc), 32'd16);
    check("full_i_tready", 32'(i_tready), 32'd0);
    check("full_head", 32'(o_tdata), 32'h100);
    check_occ(16);
    i_tdata = 17'h200; o_tready = 1'b1;
    cycle();
    o_tready = 1'b0;
    check("full_read_rdy", 32'(i_tready), 32'd1);
    check("full_next_head", 32'(o_tdata), 32'h101);
    check_occ(15);
    cycle();
    i_tvalid = 1'b0;
    check("full_17th_rdy", 32'(i_tready), 32'd0);
    check_occ(16);
    drain(60);

    // Back-to-back packets, concurrent read; MSB marks packet end
    o_tready = 1'b1; stalls = 0; out_last = 0;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 20; j++) begin
        i_tdata = {(j == 19), 16'(p * 256 + j * 7)};
        i_tvalid = 1'b1;
        if (!i_tready) stalls++;
        cycle();
        while (!(i_tready) && stalls < 100) begin stalls++; cycle(); end
      end
    end
    drain(40);
    check("pkt_stalls", 32'(stalls), 32'd0);
    check("pkt_ends", 32'(out_last), 32'd3);

    // Random valid/ready at 50%
`ifdef AXI_FIFO_OCCUPANCY_EN
    exp_sum = DEPTH;
`else
    exp_sum = 0;
`endif
    for (int k = 0; k < 300; k++) begin
      i_tvalid = 1'($urandom_range(0, 1));
      o_tready = 1'($urandom_range(0, 1));
      i_tdata  = 17'($urandom);
      cycle();
      check("occ_sum", 32'(occupied) + 32'(space), 32'(exp_sum));
    end
    drain(60);

    // Clear with 10 words stored and a write on the clear edge
    for (int i = 0; i < 10; i++) begin
      i_tdata = 17'(32'h300 + i); i_tvalid = 1'b1;
      cycle();
    end
    check_occ(10);
    i_tdata = 17'h0_0777; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; i_tvalid = 1'b0;
    exp_q.delete();
    check("clr_o_tvalid", 32'(o_tvalid), 32'd0);
    check("clr_i_tready", 32'(i_tready), 32'd1);
    check("clr_o_tdata", 32'(o_tdata), 32'd0);
    check_occ(0);
    i_tdata = 17'h1_1234; i_tvalid = 1'b1;
    cycle();
    i_tvalid = 1'b0;
    cycle();
    check("clr_lat_n1", 32'(o_tvalid), 32'd0);
    cycle();
    check("clr_lat_n2_vld", 32'(o_tvalid), 32'd1);
    check("clr_lat_n2_dat", 32'(o_tdata), 32'h1_1234);
    drain(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
